// File: rtl/bufz_bus_turnaround_drv.sv
// bufz_bus_turnaround_drv: NCH-channel tristate bus driver with registered output and break-before-make turnaround; define BUFZ_BUS_RR_EN for round-robin arbitration
module bufz_bus_turnaround_drv #(
   parameter int WIDTH    = 8,
   parameter int NCH      = 4,
   parameter int TURN_CYC = 1,
   parameter int MAX_HOLD = 0
) (
   input  logic                 CLK,
   input  logic                 RN,
   input  logic [NCH-1:0]       REQ,
   input  logic [NCH*WIDTH-1:0] DATA,
   output logic [WIDTH-1:0]     Z,
   output logic                 OE,
   output logic [NCH-1:0]       GNT,
   output logic                 BUSY
);
   localparam int OW = $clog2(NCH);
   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
   typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;
   state_t           state_q, state_d;
   logic [OW-1:0]    own_q, own_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [TW-1:0]    turn_q, turn_d;
   logic [WIDTH-1:0] dreg_q, dreg_d;
   logic             oe_q, oe_d;
   logic [NCH-1:0]   gnt_q, gnt_d;
   logic [OW-1:0]    win;
   logic             grant, rel;
`ifdef BUFZ_BUS_RR_EN
   logic [OW-1:0]    rr_ptr_q, rr_ptr_d;
   // round-robin winner: first requester at or after rr_ptr
   always_comb begin
      win = '0;
      for (int k = NCH - 1; k >= 0; k--)
         if (REQ[(int'(rr_ptr_q) + k) % NCH]) win = OW'((int'(rr_ptr_q) + k) % NCH);
   end
`else
   // fixed-priority winner: lowest requesting index
   always_comb begin
      win = '0;
      for (int k = NCH - 1; k >= 0; k--)
         if (REQ[k]) win = OW'(k);
   end
`endif
   assign grant = |REQ && (state_q == IDLE || (state_q == TURN && turn_q == '0));
   assign rel   = !REQ[own_q] || (MAX_HOLD != 0 && int'(hold_q) == MAX_HOLD);
   // next-state: grant, release into turnaround, track owner data, count down dead cycles
   always_comb begin
      state_d = state_q;
      own_d   = own_q;
      hold_d  = hold_q;
      turn_d  = turn_q;
      dreg_d  = dreg_q;
      oe_d    = oe_q;
      gnt_d   = gnt_q;
`ifdef BUFZ_BUS_RR_EN
      rr_ptr_d = rr_ptr_q;
`endif
      if (grant) begin
         state_d = DRIVE;
         own_d   = win;
         gnt_d   = NCH'(1) << win;
         oe_d    = 1'b1;
         dreg_d  = DATA[int'(win)*WIDTH +: WIDTH];
         hold_d  = HW'(1);
`ifdef BUFZ_BUS_RR_EN
         rr_ptr_d = (int'(win) == NCH - 1) ? '0 : win + OW'(1);
`endif
      end else if (state_q == DRIVE && rel) begin
         state_d = TURN;
         oe_d    = 1'b0;
         gnt_d   = '0;
         turn_d  = TW'(TURN_CYC - 1);
      end else if (state_q == DRIVE) begin
         dreg_d = DATA[int'(own_q)*WIDTH +: WIDTH];
         hold_d = (MAX_HOLD == 0 || int'(hold_q) == MAX_HOLD) ? hold_q : hold_q + HW'(1);
      end else if (state_q == TURN) begin
         state_d = (turn_q == '0) ? IDLE : TURN;
         turn_d  = (turn_q == '0) ? turn_q : turn_q - TW'(1);
      end
   end
   // state register; reset floats the bus immediately via oe_q
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_q <= IDLE;
         own_q   <= '0;
         hold_q  <= '0;
         turn_q  <= '0;
         dreg_q  <= '0;
         oe_q    <= 1'b0;
         gnt_q   <= '0;
`ifdef BUFZ_BUS_RR_EN
         rr_ptr_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         own_q   <= own_d;
         hold_q  <= hold_d;
         turn_q  <= turn_d;
         dreg_q  <= dreg_d;
         oe_q    <= oe_d;
         gnt_q   <= gnt_d;
`ifdef BUFZ_BUS_RR_EN
         rr_ptr_q <= rr_ptr_d;
`endif
      end
   end
   assign Z    = oe_q ? dreg_q : 'z;
   assign OE   = oe_q;
   assign GNT  = gnt_q;
   assign BUSY = state_q != IDLE;
endmodule

// File: tb/tb_bufz_bus_turnaround_drv.sv
// tb_bufz_bus_turnaround_drv: randomized and directed checks of the turnaround bus driver against a behavioural model
module tb_bufz_bus_turnaround_drv;
   localparam int WIDTH = 8, NCH = 4, TURN_CYC = 2, MAX_HOLD = 3;
   logic        clk = 1'b0;
   logic        rn = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] data = '0;
   wire  [7:0]  z;
   logic        oe, busy;
   logic [3:0]  gnt;
   int          n_tests = 0, n_fail = 0, n;
   logic        prev_oe = 1'b0;
   logic [3:0]  prev_gnt = '0;
   int          m_own = -1, m_gap = 0, m_held = 0, m_ptr = 0;
   logic        m_gap_on = 1'b0;
   logic [7:0]  m_data = '0;

   bufz_bus_turnaround_drv #(.WIDTH(WIDTH), .NCH(NCH), .TURN_CYC(TURN_CYC), .MAX_HOLD(MAX_HOLD)) dut (
      .CLK(clk), .RN(rn), .REQ(req), .DATA(data), .Z(z), .OE(oe), .GNT(gnt), .BUSY(busy));

   always #5 clk = ~clk;

   function automatic int pick();
      for (int k = 0; k < NCH; k++) begin
`ifdef BUFZ_BUS_RR_EN
         if (req[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
`else
         if (req[k]) return k;
`endif
      end
      return -1;
   endfunction

   // reference: an owner drives until it drops or uses up its hold budget, then the bus rests TURN_CYC cycles
   always @(posedge clk or negedge rn) begin
      if (!rn) begin
         m_own <= -1; m_gap_on <= 1'b0; m_gap <= 0; m_held <= 0; m_data <= '0; m_ptr <= 0;
      end else if (m_own >= 0) begin
         if (!req[m_own] || (MAX_HOLD != 0 && m_held == MAX_HOLD)) begin
            m_own <= -1; m_gap_on <= 1'b1; m_gap <= 0;
         end else begin
            m_data <= data[m_own*8 +: 8]; m_held <= m_held + 1;
         end
      end else if (m_gap_on && m_gap < TURN_CYC - 1) m_gap <= m_gap + 1;
      else begin
         m_gap_on <= 1'b0;
         if (pick() >= 0) begin
            m_own <= pick(); m_held <= 1; m_data <= data[pick()*8 +: 8]; m_ptr <= (pick() + 1) % NCH;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      check("oe", 32'(oe), 32'(m_own >= 0));
      check("gnt", 32'(gnt), (m_own >= 0) ? (32'(1) << m_own) : 32'(0));
      check("busy", 32'(busy), 32'(m_own >= 0 || m_gap_on));
      if (m_own >= 0) check("z", 32'(z), 32'(m_data));
      check("onehot0", 32'($onehot0(gnt)), 32'(1));
      check("oe_vs_gnt", 32'(oe), 32'(|gnt));
      if (oe && prev_oe) check("gnt_stable", 32'(gnt), 32'(prev_gnt));
      prev_oe = oe; prev_gnt = gnt;
   endtask

   task automatic count_while(input logic lvl, output int cnt);
      cnt = 0;
      while (oe === lvl && cnt < 20) begin
         cnt++;
         cyc();
      end
   endtask

   task automatic async_reset();
      rn = 1'b0; req = '0; prev_oe = 1'b0;
      #1;
      check("rst_oe", 32'(oe), 0);
      check("rst_gnt", 32'(gnt), 0);
      check("rst_busy", 32'(busy), 0);
      cyc();
      rn = 1'b1;
   endtask

   initial begin
      cyc(); cyc();
      rn = 1'b1; req = 4'b0100; data[23:16] = 8'hA5;
      cyc();
      check("t2_gnt", 32'(gnt), 32'h4);
      check("t2_z", 32'(z), 32'hA5);
      data[23:16] = 8'h3C;
      cyc();
      check("t2_z_track", 32'(z), 32'h3C);
      async_reset();
      cyc();
      check("t1_idle", 32'(busy), 0);
      req = 4'b0011;
      cyc();
      check("t3_gnt0", 32'(gnt), 32'h1);
      req = 4'b0010;
      cyc();
      count_while(1'b0, n);
      check("t3_gap", 32'(n), 32'(TURN_CYC));
      check("t3_gnt1", 32'(gnt), 32'h2);
      async_reset();
      req = 4'b1010;
      cyc(); cyc();
      check("t4_gnt", 32'(gnt), 32'h2);
      count_while(1'b1, n);
      count_while(1'b0, n);
`ifdef BUFZ_BUS_RR_EN
      check("t4_next", 32'(gnt), 32'h8);
`else
      check("t4_next", 32'(gnt), 32'h2);
`endif
      req = '0;
      for (int i = 0; i < 8; i++) cyc();
      req = 4'b1001;
      cyc();
      check("t5_gnt", 32'(gnt), 32'h1);
      count_while(1'b1, n);
      check("t5_hold", 32'(n), 32'(MAX_HOLD));
      count_while(1'b0, n);
      check("t5_gap", 32'(n), 32'(TURN_CYC));
`ifdef BUFZ_BUS_RR_EN
      check("t5_regrant", 32'(gnt), 32'h8);
`else
      check("t5_regrant", 32'(gnt), 32'h1);
`endif
      req = '0;
      for (int i = 0; i < 8; i++) cyc();
      check("t6_busy", 32'(busy), 0);
      check("t6_oe", 32'(oe), 0);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) async_reset();
         for (int b = 0; b < NCH; b++) if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
         data = $urandom;
         cyc();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
